// File: rtl/fm_buffer_ctrl_pkg.sv
// Shared defaults, FSM state encoding and sizing helper for the feature-map buffer
// controller and its downstream consumers.
package fm_buffer_ctrl_pkg;

    localparam int unsigned DEF_FM_WIDTH    = 8;
    localparam int unsigned DEF_FM_HEIGHT   = 8;
    localparam int unsigned DEF_NUM_KERNELS = 2;
    localparam int unsigned DEF_X_W         = 10;
    localparam int unsigned DEF_Y_W         = 10;
    localparam int unsigned DEF_RD_LAT      = 2;
    localparam int unsigned DEF_DEPTH       = DEF_FM_WIDTH * DEF_FM_HEIGHT;
    localparam int unsigned DEF_ADDR_W      = $clog2(DEF_DEPTH);

    // Mux select width never collapses to zero bits for a single kernel.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_SEL_W = sel_width(DEF_NUM_KERNELS);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READ  = 2'd2,
        ST_FLUSH = 2'd3
    } fm_state_e;

endpackage

// File: rtl/fm_buffer_ctrl_if.sv
// Pixel-in / RAM-address-out bundle between the rect_linear side and the read-out consumer.
interface fm_buffer_ctrl_if
    import fm_buffer_ctrl_pkg::*;
#(
    parameter int unsigned X_W    = DEF_X_W,
    parameter int unsigned Y_W    = DEF_Y_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned SEL_W  = DEF_SEL_W
);
    logic              pixel_rdy;
    logic [X_W-1:0]    fm_x_coord;
    logic [Y_W-1:0]    fm_y_coord;
    logic              mm_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic              wren;
    logic              buffer_full;
    logic [ADDR_W-1:0] rd_addr;
    logic [SEL_W-1:0]  ram_select;
    logic              rd_valid;
    logic              rd_last;
    logic              done;
    logic              drop_err;

    modport master (
        output pixel_rdy, fm_x_coord, fm_y_coord, mm_ready,
        input  wr_addr, wren, buffer_full, rd_addr, ram_select,
               rd_valid, rd_last, done, drop_err
    );

    modport slave (
        input  pixel_rdy, fm_x_coord, fm_y_coord, mm_ready,
        output wr_addr, wren, buffer_full, rd_addr, ram_select,
               rd_valid, rd_last, done, drop_err
    );
endinterface

// File: rtl/fm_buffer_ctrl_rd_seq.sv
// Read-out sequencer: address-inner / select-outer issue counter plus the RD_LAT
// delay line that turns issues into mux-output valid/last.
module fm_buffer_ctrl_rd_seq #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned NUM_KERNELS = 2,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned SEL_W       = 1,
    parameter int unsigned RD_LAT      = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_en,
    output logic              issue_last_c,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [SEL_W-1:0]  ram_select,
    output logic              rd_valid,
    output logic              rd_last
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] lst_q, lst_d;
    logic              addr_end_c;
    logic              sel_end_c;

    always_comb begin
        addr_d       = addr_q;
        sel_d        = sel_q;
        addr_end_c   = (addr_q == ADDR_W'(DEPTH - 1));
        sel_end_c    = (sel_q == SEL_W'(NUM_KERNELS - 1));
        issue_last_c = issue_en && addr_end_c && sel_end_c;
        if (issue_en) begin
            if (addr_end_c) begin
                addr_d = '0;
                sel_d  = sel_end_c ? '0 : sel_q + SEL_W'(1);
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
        // Shift in at bit 0; the oldest entry falls off the top.
        vld_d = RD_LAT'({vld_q, issue_en});
        lst_d = RD_LAT'({lst_q, issue_last_c});
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= '0;
            sel_q  <= '0;
            vld_q  <= '0;
            lst_q  <= '0;
        end else begin
            addr_q <= addr_d;
            sel_q  <= sel_d;
            vld_q  <= vld_d;
            lst_q  <= lst_d;
        end
    end

    assign rd_addr    = addr_q;
    assign ram_select = sel_q;
    assign rd_valid   = vld_q[RD_LAT-1];
    assign rd_last    = lst_q[RD_LAT-1];
endmodule

// File: rtl/fm_buffer_ctrl.sv
// Feature-map buffer controller: raster write addressing during FILL, then a full
// multi-kernel read-out once the map is complete and the consumer is ready.
module fm_buffer_ctrl
    import fm_buffer_ctrl_pkg::*;
#(
    parameter int unsigned FM_WIDTH    = DEF_FM_WIDTH,
    parameter int unsigned FM_HEIGHT   = DEF_FM_HEIGHT,
    parameter int unsigned NUM_KERNELS = DEF_NUM_KERNELS,
    parameter int unsigned X_W         = DEF_X_W,
    parameter int unsigned Y_W         = DEF_Y_W,
    parameter int unsigned RD_LAT      = DEF_RD_LAT
) (
    input  logic            clock,
    input  logic            reset,
    fm_buffer_ctrl_if.slave bus
);
    localparam int unsigned DEPTH  = FM_WIDTH * FM_HEIGHT;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned SEL_W  = sel_width(NUM_KERNELS);
    localparam int unsigned LIN_W  = ADDR_W + 1;

    fm_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wren_q, wren_d;
    logic              buffer_full_q, buffer_full_d;
    logic              done_q, done_d;
    logic              drop_err_q, drop_err_d;

    logic              in_range_c;
    logic [LIN_W-1:0]  lin_c;
    logic              issue_en_c;
    logic              issue_last_c;
    logic [ADDR_W-1:0] rd_addr;
    logic [SEL_W-1:0]  ram_select;
    logic              rd_valid;
    logic              rd_last;

    // Range check uses the full coordinate width so out-of-range pixels never alias after truncation.
    always_comb begin
        in_range_c = (bus.fm_x_coord < X_W'(FM_WIDTH)) && (bus.fm_y_coord < Y_W'(FM_HEIGHT));
        lin_c      = LIN_W'(bus.fm_y_coord) * LIN_W'(FM_WIDTH) + LIN_W'(bus.fm_x_coord);
    end

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        wren_d     = 1'b0;
        done_d     = 1'b0;
        drop_err_d = drop_err_q;
        issue_en_c = 1'b0;
        unique case (state_q)
            ST_FILL: begin
                if (bus.pixel_rdy && in_range_c) begin
                    wren_d    = 1'b1;
                    wr_addr_d = ADDR_W'(lin_c);
                end
                if (wren_q && (wr_addr_q == ADDR_W'(DEPTH - 1))) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mm_ready) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                issue_en_c = 1'b1;
                if (issue_last_c) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (rd_last) begin
                    state_d = ST_FILL;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_FILL;
        endcase
        // Includes the FLUSH->FILL cycle: FILL only takes effect on the next cycle.
        if (bus.pixel_rdy && (state_q != ST_FILL)) begin
            drop_err_d = 1'b1;
        end
        buffer_full_d = (state_d != ST_FILL);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_FILL;
            wr_addr_q     <= '0;
            wren_q        <= 1'b0;
            buffer_full_q <= 1'b0;
            done_q        <= 1'b0;
            drop_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            wren_q        <= wren_d;
            buffer_full_q <= buffer_full_d;
            done_q        <= done_d;
            drop_err_q    <= drop_err_d;
        end
    end

    fm_buffer_ctrl_rd_seq #(
        .DEPTH       (DEPTH),
        .NUM_KERNELS (NUM_KERNELS),
        .ADDR_W      (ADDR_W),
        .SEL_W       (SEL_W),
        .RD_LAT      (RD_LAT)
    ) u_rd_seq (
        .clock        (clock),
        .reset        (reset),
        .issue_en     (issue_en_c),
        .issue_last_c (issue_last_c),
        .rd_addr      (rd_addr),
        .ram_select   (ram_select),
        .rd_valid     (rd_valid),
        .rd_last      (rd_last)
    );

    assign bus.wr_addr     = wr_addr_q;
    assign bus.wren        = wren_q;
    assign bus.buffer_full = buffer_full_q;
    assign bus.done        = done_q;
    assign bus.drop_err    = drop_err_q;
    assign bus.rd_addr     = rd_addr;
    assign bus.ram_select  = ram_select;
    assign bus.rd_valid    = rd_valid;
    assign bus.rd_last     = rd_last;
endmodule

// File: tb/tb_fm_buffer_ctrl.sv
// Bench for fm_buffer_ctrl at 4x4 map, 2 kernels, RD_LAT 2: vector table for the fill
// path, scoreboard queues for writes and read-out valids, hand sequences for the rest.
module tb_fm_buffer_ctrl;
    import fm_buffer_ctrl_pkg::*;

    localparam int unsigned FW    = 4;
    localparam int unsigned FH    = 4;
    localparam int unsigned NK    = 2;
    localparam int unsigned XW    = 10;
    localparam int unsigned YW    = 10;
    localparam int unsigned RDL   = 2;
    localparam int unsigned DEPTH = FW * FH;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned SW    = sel_width(NK);

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc = 0;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        int unsigned due;
        logic [AW-1:0] addr;
    } wr_exp_t;

    typedef struct {
        int unsigned due;
        logic last;
    } rd_exp_t;

    typedef struct {
        logic        rdy;
        int unsigned x;
        int unsigned y;
        logic        exp_wren;
        int unsigned exp_addr;
    } vec_t;

    wr_exp_t wr_q[$];
    rd_exp_t rd_q[$];
    vec_t    tbl[$];

    fm_buffer_ctrl_if #(.X_W(XW), .Y_W(YW), .ADDR_W(AW), .SEL_W(SW)) bus ();

    fm_buffer_ctrl #(
        .FM_WIDTH    (FW),
        .FM_HEIGHT   (FH),
        .NUM_KERNELS (NK),
        .X_W         (XW),
        .Y_W         (YW),
        .RD_LAT      (RDL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every cycle either an expected item is due or the output must be idle.
    always @(negedge clock) begin
        if (mon_en) begin
            if (wr_q.size() > 0 && wr_q[0].due == cyc) begin
                chk("wr_wren", 32'(bus.wren), 32'd1);
                if (bus.wren) chk("wr_addr", 32'(bus.wr_addr), 32'(wr_q[0].addr));
                void'(wr_q.pop_front());
            end else begin
                chk("wr_idle", 32'(bus.wren), 32'd0);
            end
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                chk("rd_valid", 32'(bus.rd_valid), 32'd1);
                chk("rd_last", 32'(bus.rd_last), 32'(rd_q[0].last));
                void'(rd_q.pop_front());
            end else begin
                chk("rd_valid_idle", 32'(bus.rd_valid), 32'd0);
                chk("rd_last_idle", 32'(bus.rd_last), 32'd0);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wren"}, 32'(bus.wren), 32'd0);
        chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
        chk({tag, "_buffer_full"}, 32'(bus.buffer_full), 32'd0);
        chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
        chk({tag, "_ram_select"}, 32'(bus.ram_select), 32'd0);
        chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
        chk({tag, "_rd_last"}, 32'(bus.rd_last), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_drop_err"}, 32'(bus.drop_err), 32'd0);
    endtask

    task automatic fill();
        int unsigned a = 0;
        for (int y = 0; y < int'(FH); y++) begin
            for (int x = 0; x < int'(FW); x++) begin
                bus.pixel_rdy  = 1'b1;
                bus.fm_x_coord = XW'(x);
                bus.fm_y_coord = YW'(y);
                wr_q.push_back('{cyc + 1, AW'(a)});
                a++;
                tick();
            end
        end
        bus.pixel_rdy = 1'b0;
        chk("full_not_yet", 32'(bus.buffer_full), 32'd0);
        tick();
        chk("full_set", 32'(bus.buffer_full), 32'd1);
    endtask

    // mm_ready accepted at T; drop_at injects a pixel during issue n; reset_at aborts at issue n.
    task automatic readout(input int drop_at, input int reset_at);
        int unsigned t0;
        bit aborted = 1'b0;
        t0 = cyc;
        bus.mm_ready = 1'b1;
        for (int i = 0; i < int'(NK * DEPTH); i++) begin
            if (reset_at < 0 || i <= reset_at - int'(RDL))
                rd_q.push_back('{t0 + RDL + 1 + i, (i == int'(NK * DEPTH) - 1)});
        end
        tick();
        bus.mm_ready = 1'b0;
        for (int i = 0; i < int'(NK * DEPTH); i++) begin
            chk("issue_addr", 32'(bus.rd_addr), 32'(i % int'(DEPTH)));
            chk("issue_sel", 32'(bus.ram_select), 32'(i / int'(DEPTH)));
            chk("busy_full", 32'(bus.buffer_full), 32'd1);
            chk("busy_done", 32'(bus.done), 32'd0);
            if (i == reset_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                chk_all_zero("abort");
                aborted = 1'b1;
                break;
            end
            bus.pixel_rdy = (i == drop_at);
            tick();
        end
        bus.pixel_rdy = 1'b0;
        if (!aborted) begin
            tick();
            chk("done_early", 32'(bus.done), 32'd0);
            chk("full_before_done", 32'(bus.buffer_full), 32'd1);
            tick();
            chk("done_pulse", 32'(bus.done), 32'd1);
            chk("full_clear", 32'(bus.buffer_full), 32'd0);
            tick();
            chk("done_one_cycle", 32'(bus.done), 32'd0);
        end else begin
            repeat (6) begin
                tick();
                chk("abort_no_done", 32'(bus.done), 32'd0);
                chk("abort_not_full", 32'(bus.buffer_full), 32'd0);
            end
        end
    endtask

    initial begin
        int unsigned a;
        // Out-of-range (including values that would alias after truncation), then raster with a gap.
        tbl.push_back('{1'b1, 4, 0, 1'b0, 0});
        tbl.push_back('{1'b1, 0, 4, 1'b0, 0});
        tbl.push_back('{1'b1, 1023, 0, 1'b0, 0});
        tbl.push_back('{1'b1, 0, 8, 1'b0, 0});
        tbl.push_back('{1'b1, 3, 4, 1'b0, 0});
        tbl.push_back('{1'b0, 2, 1, 1'b0, 0});
        a = 0;
        for (int y = 0; y < int'(FH); y++) begin
            for (int x = 0; x < int'(FW); x++) begin
                tbl.push_back('{1'b1, x, y, 1'b1, a});
                a++;
                if (a == 8) tbl.push_back('{1'b0, 3, 3, 1'b0, 0});
            end
        end

        bus.pixel_rdy  = 1'b0;
        bus.fm_x_coord = '0;
        bus.fm_y_coord = '0;
        bus.mm_ready   = 1'b0;
        reset          = 1'b1;
        repeat (2) tick();
        chk_all_zero("reset");
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            bus.pixel_rdy  = tbl[i].rdy;
            bus.fm_x_coord = XW'(tbl[i].x);
            bus.fm_y_coord = YW'(tbl[i].y);
            if (tbl[i].exp_wren) wr_q.push_back('{cyc + 1, AW'(tbl[i].exp_addr)});
            tick();
            chk("tbl_drop_err", 32'(bus.drop_err), 32'd0);
        end
        bus.pixel_rdy = 1'b0;
        chk("tbl_full_not_yet", 32'(bus.buffer_full), 32'd0);
        tick();
        chk("tbl_full_set", 32'(bus.buffer_full), 32'd1);

        repeat (10) begin
            chk("hold_full", 32'(bus.buffer_full), 32'd1);
            chk("hold_rd_addr", 32'(bus.rd_addr), 32'd0);
            chk("hold_sel", 32'(bus.ram_select), 32'd0);
            tick();
        end
        readout(-1, -1);
        chk("clean_drop_err", 32'(bus.drop_err), 32'd0);

        fill();
        readout(5, -1);
        chk("drop_err_set", 32'(bus.drop_err), 32'd1);
        repeat (3) tick();
        chk("drop_err_sticky", 32'(bus.drop_err), 32'd1);

        fill();
        readout(-1, 10);

        fill();
        readout(-1, -1);
        chk("refill_drop_err", 32'(bus.drop_err), 32'd0);

        repeat (4) tick();
        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
